// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a serialiser with its own baud counter.
// Latency: a byte pushed into an empty FIFO while idle drives the start bit two clocks later.
// Backpressure: tx_ready drops while the FIFO holds FIFO_DEPTH bytes; held tx_valid simply waits.

// Generic synchronous FIFO with show-ahead read data and a registered occupancy count.
// Latency: a written entry is visible on rd_dat/rd_vld one clock after the write.
// Backpressure: wr_rdy is low when full; a write attempt while full is ignored.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    output logic [AW:0]      count
);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign wr_rdy = (count != FULL_CNT);
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_rdy && rd_vld;

    // Storage array: written on every accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks push/pop balance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          rs232_tx,
    output logic          tx_busy,
    output logic [AW:0]   fifo_count
);
    localparam int              CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int              CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BAUD_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   BAUD_ONE     = CW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          baud_end;
    logic          head_vld;
    logic [7:0]    head_dat;
    logic          pop;

    // Pop only when the line is free for a new frame: idle, or the final stop-bit clock.
    assign baud_end = (baud_cnt == BAUD_LAST);
    assign pop      = head_vld && ((state == IDLE) || ((state == STOP) && baud_end));

    fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (tx_valid),
        .wr_rdy (tx_ready),
        .wr_dat (tx_data),
        .rd_rdy (pop),
        .rd_vld (head_vld),
        .rd_dat (head_dat),
        .count  (fifo_count)
    );

    // Frame sequencer; the line is a registered image of the current state, one clock behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_busy  <= 1'b0;
            rs232_tx <= 1'b1;
        end else begin
            case (state)
                START:   rs232_tx <= 1'b0;
                DATA:    rs232_tx <= shift[0];
                default: rs232_tx <= 1'b1;
            endcase

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        state   <= START;
                        shift   <= head_dat;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (baud_end) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            state <= START;
                            shift <= head_dat;
                        end else begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at 10 clocks per bit.
// Accepted bytes are queued at the handshake and compared against a line-level UART receiver.
// Directed scenarios plus a random burst; every comparison is an immediate assertion.
module tb_uart_tx_fifo;
    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DEPTH    = 16;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * CPB;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       rs232_tx;
    logic       tx_busy;
    logic [4:0] fifo_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         start_q[$];
    int         frame_err = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rs232_tx   (rs232_tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: every byte that completes a handshake must later appear on the line, in order.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) exp_q.push_back(tx_data);
    end

    // Line receiver: sample each bit mid-cell from the first low sample of the start bit.
    logic       rx_active = 1'b0;
    int         rx_t      = 0;
    logic [7:0] rx_byte   = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (rs232_tx === 1'b0) begin
                rx_active = 1'b1;
                rx_t      = 0;
                start_q.push_back(cyc);
            end
        end else begin
            rx_t = rx_t + 1;
            if (rx_t % CPB == CPB / 2) begin
                if (rx_t / CPB == 0) begin
                    if (rs232_tx !== 1'b0) frame_err++;
                end else if (rx_t / CPB <= 8) begin
                    rx_byte[rx_t / CPB - 1] = rs232_tx;
                end else begin
                    if (rs232_tx === 1'b1) rx_q.push_back(rx_byte);
                    else frame_err++;
                    rx_active = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_queues();
        exp_q.delete();
        rx_q.delete();
        start_q.delete();
    endtask

    task automatic check_stream(input string tag);
        check({tag, " byte count"}, rx_q.size(), exp_q.size());
        while (exp_q.size() > 0 && rx_q.size() > 0)
            check({tag, " byte"}, rx_q.pop_front(), exp_q.pop_front());
        clear_queues();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((tx_busy !== 1'b0 || fifo_count !== 5'd0) && n < budget) begin
            tick();
            n++;
        end
        check({tag, " idle within budget"}, (tx_busy === 1'b0 && fifo_count === 5'd0), 1);
        repeat (5) tick();
    endtask

    initial begin
        int         bad;
        int         busy_n;
        int         acc;
        int         n;
        int         peak;
        logic [9:0] frame;
        logic [7:0] x;
        logic [7:0] y;

        // Reset state
        repeat (3) tick();
        check("reset line", rs232_tx, 1);
        check("reset busy", tx_busy, 0);
        check("reset count", fifo_count, 0);
        check("reset ready", tx_ready, 1);
        rst_n = 1'b1;
        repeat (3) tick();

        // Single byte 0x55: two-clock latency, exact waveform, busy for one frame
        clear_queues();
        tx_data = 8'h55; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
        check("t1 count after push", fifo_count, 1);
        check("t1 line before pop", rs232_tx, 1);
        tick();
        check("t1 count after pop", fifo_count, 0);
        check("t1 busy at start entry", tx_busy, 1);
        check("t1 line one clock after pop", rs232_tx, 1);
        frame  = {1'b1, 8'h55, 1'b0};
        bad    = 0;
        busy_n = 1;
        for (int c = 0; c < FRAME; c++) begin
            tick();
            if (rs232_tx !== frame[c / CPB]) bad++;
            if (tx_busy === 1'b1) busy_n++;
        end
        check("t1 waveform errors", bad, 0);
        check("t1 busy cycles", busy_n, FRAME);
        tick();
        check("t1 line idle after", rs232_tx, 1);
        check_stream("t1");

        // Back-to-back frames
        tx_valid = 1'b1;
        tx_data = 8'hA5; tick();
        tx_data = 8'h0F; tick();
        tx_data = 8'hFF; tick();
        tx_valid = 1'b0;
        peak = fifo_count;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fifo_count > peak) peak = fifo_count;
        end
        wait_idle("t2", 600);
        check("t2 peak count", peak, 2);
        check("t2 frames seen", start_q.size(), 3);
        check("t2 gap 0-1", start_q[1] - start_q[0], FRAME);
        check("t2 gap 1-2", start_q[2] - start_q[1], FRAME);
        check_stream("t2");

        // Fill the FIFO with an incrementing pattern
        tx_valid = 1'b1; tx_data = 8'h00; acc = 0;
        for (int i = 0; i < 40 && tx_ready === 1'b1; i++) begin
            tick();
            acc++;
            tx_data = tx_data + 8'd1;
        end
        check("t3 bytes accepted", acc, DEPTH + 1);
        check("t3 count full", fifo_count, DEPTH);
        check("t3 ready low", tx_ready, 0);
        check("t3 busy", tx_busy, 1);

        // Hold 0xEE against a full FIFO
        tx_data = 8'hEE; bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (fifo_count !== 5'd16 || tx_ready !== 1'b0) bad++;
        end
        check("t3 full hold violations", bad, 0);
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("t3 ready reopened", tx_ready, 1);
        check("t3 count after frame 0", fifo_count, DEPTH - 1);
        tick();
        tx_valid = 1'b0;
        check("t3 count refilled", fifo_count, DEPTH);
        check("t3 ready low again", tx_ready, 0);
        wait_idle("t3", 2500);
        check("t3 expected length", exp_q.size(), DEPTH + 2);
        check("t3 last expected is EE", exp_q[DEPTH + 1], 8'hEE);
        check_stream("t3");

        // Reset in the middle of data bit 3 with five bytes queued
        tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_data = (i == 0) ? 8'($urandom & 32'hF7) : 8'($urandom);
            tick();
        end
        tx_valid = 1'b0;
        repeat (40) tick();
        check("t4 line low in bit 3", rs232_tx, 0);
        check("t4 queued", fifo_count, 5);
        #2 rst_n = 1'b0;
        #1;
        check("t4 async line", rs232_tx, 1);
        check("t4 async count", fifo_count, 0);
        check("t4 async busy", tx_busy, 0);
        check("t4 async ready", tx_ready, 1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        clear_queues();
        bad = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (rs232_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("t4 quiet after reset", bad, 0);
        check("t4 no spurious frame", rx_q.size(), 0);
        check("t4 count stays empty", fifo_count, 0);
        clear_queues();

        // Push 0x3C on the last stop clock while one byte is queued
        x = 8'($urandom); y = 8'($urandom);
        tx_valid = 1'b1;
        tx_data = x; tick();
        tx_data = y; tick();
        tx_valid = 1'b0;
        repeat (FRAME - 1) tick();
        check("t5 count before", fifo_count, 1);
        tx_data = 8'h3C; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
        check("t5 count unchanged", fifo_count, 1);
        check("t5 busy held", tx_busy, 1);
        wait_idle("t5", 600);
        check("t5 frames seen", start_q.size(), 3);
        check("t5 gap 0-1", start_q[1] - start_q[0], FRAME);
        check("t5 gap 1-2", start_q[2] - start_q[1], FRAME);
        check_stream("t5");

        // Push into an empty FIFO on the last stop clock: one idle clock before the next frame
        x = 8'($urandom); y = 8'($urandom);
        tx_data = x; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
        repeat (FRAME) tick();
        tx_data = y; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
        check("t6 count after late push", fifo_count, 1);
        check("t6 idle for one clock", tx_busy, 0);
        tick();
        check("t6 popped next clock", fifo_count, 0);
        check("t6 busy again", tx_busy, 1);
        wait_idle("t6", 400);
        check("t6 frames seen", start_q.size(), 2);
        check("t6 gap", start_q[1] - start_q[0], FRAME + 1);
        check_stream("t6");

        // Random burst with random valid gaps
        for (int i = 0; i < 60; i++) begin
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = 8'($urandom);
            tick();
        end
        tx_valid = 1'b0;
        wait_idle("t7", 5000);
        check_stream("t7");

        check("framing errors", frame_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
